// File: rtl/sata_xcvr_rst_supervisor.sv
// Reset supervisor for the SATA transceiver reset controller; qualifies phy_ready.
// Optional loss-of-lock monitor in READY: `define SATA_XCVR_RST_SUP_LOL_MON_EN
module sata_xcvr_rst_supervisor #(
  parameter int RST_PULSE     = 32,
  parameter int READY_TIMEOUT = 1000000,
  parameter int LOL_FILTER    = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic       xcvr_reset,
  input  logic       tx_ready,
  input  logic       rx_ready,
  input  logic       rx_is_lockedtodata,
  input  logic       tx_cal_busy,
  input  logic       rx_cal_busy,
  input  logic       rearm,
  output logic       phy_ready,
  output logic [7:0] retry_cnt,
  output logic       timeout_err
);

  localparam int PW = $clog2(RST_PULSE + 1);
  localparam int TW = $clog2(READY_TIMEOUT + 1);
  localparam logic [PW-1:0] PULSE_END = PW'(RST_PULSE - 1);
  localparam logic [TW-1:0] TIMER_END = TW'(READY_TIMEOUT - 1);

  if (RST_PULSE < 2) begin : g_bad_pulse
    $error("RST_PULSE must be at least 2");
  end
  if (READY_TIMEOUT < 2) begin : g_bad_timeout
    $error("READY_TIMEOUT must be at least 2");
  end
  if (LOL_FILTER < 1) begin : g_bad_lol
    $error("LOL_FILTER must be at least 1");
  end

  typedef enum logic [1:0] {
    RST,
    WAIT_READY,
    READY
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] pulse;
  logic [TW-1:0] timer;
  logic          sync1;
  logic          lock_s;
  logic          cal;
  logic          link_up;
  logic          lol_hit;
  logic          restart;
  logic          retry_inc;
  logic          to_set;
  logic          to_clr;

  assign cal     = tx_cal_busy | rx_cal_busy;
  assign link_up = tx_ready & rx_ready;

`ifdef SATA_XCVR_RST_SUP_LOL_MON_EN
  localparam int LW = $clog2(LOL_FILTER + 1);
  localparam logic [LW-1:0] LOL_END = LW'(LOL_FILTER - 1);

  logic [LW-1:0] lol;

  // Counts consecutive low lock samples while READY
  assign lol_hit = (state == READY) & ~lock_s & (lol == LOL_END);

  always_ff @(posedge clock) begin
    if (reset) begin
      lol <= '0;
    end else if (restart || state != READY || lock_s) begin
      lol <= '0;
    end else begin
      lol <= lol + LW'(1);
    end
  end
`else
  assign lol_hit = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    retry_inc = 1'b0;
    to_set    = 1'b0;
    to_clr    = 1'b0;
    if (rearm) begin
      state_n = RST;
      to_clr  = 1'b1;
    end else begin
      unique case (state)
        RST: begin
          if (pulse == PULSE_END) state_n = WAIT_READY;
        end
        WAIT_READY: begin
          if (link_up && lock_s) begin
            state_n = READY;
          end else if (!cal && timer == TIMER_END) begin
            state_n   = RST;
            to_set    = 1'b1;
            retry_inc = 1'b1;
          end
        end
        READY: begin
          if (!link_up || lol_hit) begin
            state_n   = RST;
            retry_inc = 1'b1;
          end
        end
        default: state_n = RST;
      endcase
    end
  end

  // Any state entry, including rearm while already in RST, restarts counters
  assign restart = rearm | (state_n != state);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RST;
      pulse       <= '0;
      timer       <= '0;
      sync1       <= 1'b0;
      lock_s      <= 1'b0;
      retry_cnt   <= '0;
      timeout_err <= 1'b0;
      xcvr_reset  <= 1'b1;
      phy_ready   <= 1'b0;
    end else begin
      state      <= state_n;
      sync1      <= rx_is_lockedtodata;
      lock_s     <= sync1;
      xcvr_reset <= (state_n == RST);
      phy_ready  <= (state_n == READY);
      if (restart) begin
        pulse <= '0;
      end else if (state == RST) begin
        pulse <= pulse + PW'(1);
      end
      if (restart) begin
        timer <= '0;
      end else if (state == WAIT_READY && !cal) begin
        timer <= timer + TW'(1);
      end
      if (retry_inc && retry_cnt != 8'hFF) begin
        retry_cnt <= retry_cnt + 8'd1;
      end
      if (to_clr) begin
        timeout_err <= 1'b0;
      end else if (to_set) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sata_xcvr_rst_supervisor.md
# sata_xcvr_rst_supervisor

Supervisor on the consuming end of the SATA transceiver reset-controller handshake. It drives the reset controller's `reset` input and watches the controller's `tx_ready`/`rx_ready`, together with the transceiver's `rx_is_lockedtodata` and calibration-busy flags. It re-issues the reset sequence on timeout or loss of link readiness and presents a single qualified `phy_ready` to the SATA PHY/link layer.

## Interface
Parameters:
- `RST_PULSE`, 32: cycles `xcvr_reset` is held high per reset attempt (≥2).
- `READY_TIMEOUT`, 1000000: cycles allowed in WAIT_READY before a retry (≥2).
- `LOL_FILTER`, 16: consecutive cycles synchronized lock must be low to count as loss of lock (≥1).

Ports:
- `clock`  in  1  single clock. All logic is on this clock.
- `reset`  in  1  synchronous, active-high reset.
- `xcvr_reset`  out  1  reset request to the transceiver reset controller.
- `tx_ready`  in  1  from the reset controller; already in the `clock` domain.
- `rx_ready`  in  1  from the reset controller; already in the `clock` domain.
- `rx_is_lockedtodata`  in  1  from the transceiver; asynchronous, double-flop synchronized internally.
- `tx_cal_busy`, `rx_cal_busy`  in  1 each  calibration in progress; freezes the timeout timer.
- `rearm`  in  1  single-cycle request to restart the reset sequence.
- `phy_ready`  out  1  transceiver fully up and locked.
- `retry_cnt`  out  8  saturating count of automatic retries (timeout or readiness loss).
- `timeout_err`  out  1  sticky flag, set on any WAIT_READY timeout.

## Operation
- Internal signal `lock_s` is `rx_is_lockedtodata` after a 2-flop synchronizer. The synchronizer flops reset to 0.
- FSM states: RST, WAIT_READY, READY.
- **RST**
  - `xcvr_reset`=1, `phy_ready`=0.
  - The pulse counter counts 0..RST_PULSE-1, then the FSM moves to WAIT_READY.
- **WAIT_READY**
  - `xcvr_reset`=0. The timer increments each cycle unless `tx_cal_busy|rx_cal_busy` is high, in which case it holds.
  - If `tx_ready & rx_ready & lock_s`, go to READY.
  - Otherwise, when the timer reaches READY_TIMEOUT-1 and no cal is busy: set `timeout_err`, increment `retry_cnt`, go to RST.
- **READY**
  - `phy_ready`=1.
  - If `tx_ready` or `rx_ready` goes low, increment `retry_cnt` and go to RST on the next cycle.
  - Loss of lock, when monitoring is enabled (see Configuration): increment `retry_cnt` and go to RST.
- **`rearm`**, in any state:
  - Go to RST and restart the pulse counter.
  - Clear `timeout_err`. Do not increment `retry_cnt`.
  - A `rearm` in RST restarts the pulse from 0.
- **Priorities**
  - `rearm` > timeout/readiness loss.
  - In WAIT_READY, readiness > timeout when both occur in the same cycle.
- **Counters**
  - Pulse, timer and LOL counters are `$clog2(param+1)` bits wide.
  - `retry_cnt` saturates at 255. It is cleared only by `reset`.
  - Every counter clears when its state is entered.

## Timing
- **Reset values**: state RST, `xcvr_reset`=1, `phy_ready`=0, `retry_cnt`=0, `timeout_err`=0, all counters 0.
- **Reset release**: `xcvr_reset` stays high exactly RST_PULSE cycles after the first cycle with `reset` low. It falls on the same edge the FSM enters WAIT_READY.
- **All outputs are registered.**
  - `phy_ready` rises 1 cycle after the qualifying condition is sampled in WAIT_READY.
  - Lock input to `phy_ready` latency is 3 cycles: 2 synchronizer + 1.
- **Readiness drop**: `phy_ready` falls and `xcvr_reset` rises on the same edge, 1 cycle after `tx_ready` or `rx_ready` is sampled low.
- **Timeout**: with no cal busy, the timeout fires READY_TIMEOUT cycles after WAIT_READY entry. Each cycle with cal busy extends this by one cycle.
- **Reset mid-operation**: `reset` high in any state returns to the reset values on the next edge.

## Configuration
- Macro: `SATA_XCVR_RST_SUP_LOL_MON_EN`.
- **Defined**:
  - In READY, a counter counts consecutive cycles of `lock_s`=0 and clears whenever `lock_s`=1.
  - On reaching LOL_FILTER, the FSM goes to RST and `retry_cnt` increments.
  - Glitches shorter than LOL_FILTER cycles are ignored.
- **Undefined**:
  - No LOL counter is built.
  - `lock_s` only qualifies entry to READY. Lock drops while in READY are ignored.

## Test plan
- **Nominal bring-up**: `reset` released. `tx_ready`, `rx_ready` and lock go high 100 cycles after `xcvr_reset` falls. Require `xcvr_reset` high for 32 cycles, `phy_ready`=1 at lock+3 cycles, `retry_cnt`=0.
- **Timeout with cal freeze** (READY_TIMEOUT=50): ready inputs never asserted, `tx_cal_busy` high for 10 cycles inside WAIT_READY. Require the retry at cycle 60 of WAIT_READY, `timeout_err`=1, `retry_cnt`=1, a new 32-cycle `xcvr_reset` pulse.
- **Readiness loss**: in READY, `rx_ready` low for 1 cycle. Require `phy_ready`=0 and `xcvr_reset`=1 on the next edge, `retry_cnt` incremented.
- **LOL filter** (macro defined, LOL_FILTER=16): a 15-cycle lock dropout keeps `phy_ready`=1. A 16-cycle dropout forces RST. With the macro undefined, a 100-cycle dropout leaves `phy_ready`=1.
- **rearm priority**: `rearm` in the same cycle as a timeout. Require RST with `retry_cnt` unchanged and `timeout_err`=0.
- **Saturation**: force 300 timeouts. Require `retry_cnt`=255.
